// File: rtl/sema_access_ctrl_if.sv
// sema_access_ctrl_if
// Groups the MEM-stage request/response handshake and the two semaphore
// memory handshakes used by sema_access_ctrl.
//   requester : rd_req_i, wr_req_i, wr_data_i -> done_o, rd_data_o, timeout_o, busy_o
//   bit2byte  : sema_valid_i, sema_data_i -> sema_ready_o
//   byte2bit  : sema_is_empty_i -> sema_write_o, sema_data_o
// slave  : view of the controller
// master : view of the requester and the semaphore memories driving it
interface sema_access_ctrl_if;
  logic rd_req_i;
  logic wr_req_i;
  logic wr_data_i;
  logic done_o;
  logic rd_data_o;
  logic timeout_o;
  logic busy_o;
  logic sema_valid_i;
  logic sema_data_i;
  logic sema_ready_o;
  logic sema_is_empty_i;
  logic sema_write_o;
  logic sema_data_o;

  modport slave (
    input  rd_req_i, wr_req_i, wr_data_i,
    input  sema_valid_i, sema_data_i, sema_is_empty_i,
    output done_o, rd_data_o, timeout_o, busy_o,
    output sema_ready_o, sema_write_o, sema_data_o
  );

  modport master (
    output rd_req_i, wr_req_i, wr_data_i,
    output sema_valid_i, sema_data_i, sema_is_empty_i,
    input  done_o, rd_data_o, timeout_o, busy_o,
    input  sema_ready_o, sema_write_o, sema_data_o
  );
endinterface

// File: rtl/sema_access_ctrl.sv
// sema_access_ctrl
// Sequences single-bit semaphore reads/writes from the MEM stage with a
// wait-state timeout.
// Ports:
//   clk  - single clock, rising edge
//   rstn - synchronous active-low reset
//   bus  - sema_access_ctrl_if.slave (requests, completion, semaphore handshakes)
// Parameter:
//   TIMEOUT_CYCLES - wait-state cycles before abort, 0 disables the timeout
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a request, read has priority over write
// RD_WAIT  | waiting for sema_valid_i, counting wait cycles
// RD_ACK   | one cycle: sema_ready_o + done_o, read bit already captured
// WR_WAIT  | waiting for sema_is_empty_i, counting wait cycles
// WR_PULSE | one cycle: sema_write_o + done_o with the latched bit
// RELEASE  | one dead cycle so the requester can drop its request
module sema_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rstn,
  sema_access_ctrl_if.slave   bus
);

  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_ACK   = 3'd2,
    WR_WAIT  = 3'd3,
    WR_PULSE = 3'd4,
    RELEASE  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rd_data_q, rd_data_d;
  logic        wr_bit_q, wr_bit_d;

  logic        in_wait;
  logic        wait_ok;
  logic        to_hit;

  logic        done;
  logic        timeout;
  logic        ready;
  logic        write;
  logic        busy;

  // A satisfied wait condition always beats the timeout in the same cycle.
  always_comb begin
    in_wait = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    wait_ok = (state_q == RD_WAIT) ? bus.sema_valid_i : bus.sema_is_empty_i;
    to_hit  = TO_EN && in_wait && !wait_ok && (cnt_q == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_data_q <= 1'b0;
      wr_bit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      wr_bit_q  <= wr_bit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    wr_bit_d  = wr_bit_q;
    if (in_wait) begin
      // Saturate rather than wrap so a disabled timeout never re-arms.
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end
    case (state_q)
      IDLE: begin
        if (bus.rd_req_i) begin
          state_d = RD_WAIT;
          cnt_d   = '0;
        end else if (bus.wr_req_i) begin
          state_d  = WR_WAIT;
          cnt_d    = '0;
          wr_bit_d = bus.wr_data_i;
        end
      end
      RD_WAIT: begin
        if (bus.sema_valid_i) begin
          rd_data_d = bus.sema_data_i;
          state_d   = RD_ACK;
        end else if (to_hit) begin
          state_d = RELEASE;
        end
      end
      WR_WAIT: begin
        if (bus.sema_is_empty_i) begin
          state_d = WR_PULSE;
        end else if (to_hit) begin
          state_d = RELEASE;
        end
      end
      RD_ACK:   state_d = RELEASE;
      WR_PULSE: state_d = RELEASE;
      RELEASE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Strobes are masked while rstn is low so a reset never lets a pending
  // acknowledge or write escape.
  always_comb begin
    done    = 1'b0;
    timeout = 1'b0;
    ready   = 1'b0;
    write   = 1'b0;
    busy    = 1'b0;
    if (rstn) begin
      busy = (state_q != IDLE);
      case (state_q)
        RD_ACK: begin
          ready = 1'b1;
          done  = 1'b1;
        end
        WR_PULSE: begin
          write = 1'b1;
          done  = 1'b1;
        end
        RD_WAIT, WR_WAIT: begin
          if (to_hit) begin
            done    = 1'b1;
            timeout = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done_o       = done;
  assign bus.timeout_o    = timeout;
  assign bus.busy_o       = busy;
  assign bus.sema_ready_o = ready;
  assign bus.sema_write_o = write;
  assign bus.rd_data_o    = rd_data_q;
  assign bus.sema_data_o  = wr_bit_q;

endmodule

// File: tb/tb_sema_access_ctrl.sv
// tb_sema_access_ctrl
// Directed bench for sema_access_ctrl: dut_a uses the default timeout,
// dut_b uses TIMEOUT_CYCLES=4. Expected completions are queued when a
// request is driven and checked when done_o appears.
module tb_sema_access_ctrl;

  logic clk;
  logic rstn_a;
  logic rstn_b;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    bit is_rd;
    bit tmo;
    bit rd;
    bit wd;
    int cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;
  logic [3:0] prev_a = 4'b0;
  logic [3:0] prev_b = 4'b0;

  sema_access_ctrl_if ia ();
  sema_access_ctrl_if ib ();

  sema_access_ctrl dut_a (
    .clk  (clk),
    .rstn (rstn_a),
    .bus  (ia)
  );

  sema_access_ctrl #(.TIMEOUT_CYCLES(4)) dut_b (
    .clk  (clk),
    .rstn (rstn_b),
    .bus  (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the caller at the negedge where done_o was seen.
  task automatic wait_done(input bit sel, input int budget);
    int  k    = 0;
    bit  seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk);
      seen = sel ? ib.done_o : ia.done_o;
      k++;
    end
    chk(sel ? "b_done_seen" : "a_done_seen", seen, 1'b1);
  endtask

  always @(negedge clk) begin
    if (ia.done_o) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 1'b1, 1'b0);
      end else begin
        e_a = q_a.pop_front();
        chk_int("a_latency", cyc, e_a.cyc);
        chk("a_timeout", ia.timeout_o, e_a.tmo);
        chk("a_rd_data", ia.rd_data_o, e_a.rd);
        chk("a_ready", ia.sema_ready_o, e_a.is_rd & ~e_a.tmo);
        chk("a_write", ia.sema_write_o, ~e_a.is_rd & ~e_a.tmo);
        if (!e_a.is_rd && !e_a.tmo) chk("a_sema_data", ia.sema_data_o, e_a.wd);
      end
    end else begin
      chk_int("a_strobe_without_done",
              int'({ia.sema_ready_o, ia.sema_write_o, ia.timeout_o}), 0);
    end
    chk_int("a_pulse_run",
            int'(prev_a & {ia.done_o, ia.timeout_o, ia.sema_ready_o, ia.sema_write_o}), 0);
    prev_a = {ia.done_o, ia.timeout_o, ia.sema_ready_o, ia.sema_write_o};
  end

  always @(negedge clk) begin
    if (ib.done_o) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 1'b1, 1'b0);
      end else begin
        e_b = q_b.pop_front();
        chk_int("b_latency", cyc, e_b.cyc);
        chk("b_timeout", ib.timeout_o, e_b.tmo);
        chk("b_rd_data", ib.rd_data_o, e_b.rd);
        chk("b_ready", ib.sema_ready_o, e_b.is_rd & ~e_b.tmo);
        chk("b_write", ib.sema_write_o, ~e_b.is_rd & ~e_b.tmo);
        if (!e_b.is_rd && !e_b.tmo) chk("b_sema_data", ib.sema_data_o, e_b.wd);
      end
    end else begin
      chk_int("b_strobe_without_done",
              int'({ib.sema_ready_o, ib.sema_write_o, ib.timeout_o}), 0);
    end
    chk_int("b_pulse_run",
            int'(prev_b & {ib.done_o, ib.timeout_o, ib.sema_ready_o, ib.sema_write_o}), 0);
    prev_b = {ib.done_o, ib.timeout_o, ib.sema_ready_o, ib.sema_write_o};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed time expired expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ia.rd_req_i = 0; ia.wr_req_i = 0; ia.wr_data_i = 0;
    ia.sema_valid_i = 0; ia.sema_data_i = 0; ia.sema_is_empty_i = 0;
    ib.rd_req_i = 0; ib.wr_req_i = 0; ib.wr_data_i = 0;
    ib.sema_valid_i = 0; ib.sema_data_i = 0; ib.sema_is_empty_i = 0;
    rstn_a = 0;
    rstn_b = 0;
    tick(2);
    @(negedge clk);
    chk_int("a_reset_outputs", int'({ia.done_o, ia.rd_data_o, ia.timeout_o, ia.busy_o,
            ia.sema_ready_o, ia.sema_write_o, ia.sema_data_o}), 0);
    chk_int("b_reset_outputs", int'({ib.done_o, ib.rd_data_o, ib.timeout_o, ib.busy_o,
            ib.sema_ready_o, ib.sema_write_o, ib.sema_data_o}), 0);
    tick(1);
    rstn_a = 1;
    rstn_b = 1;
    tick(1);

    // Read with data already valid: done at N+2, idle at N+4.
    ia.sema_valid_i = 1; ia.sema_data_i = 1; ia.rd_req_i = 1;
    q_a.push_back('{is_rd:1'b1, tmo:1'b0, rd:1'b1, wd:1'b0, cyc:cyc + 2});
    wait_done(1'b0, 8);
    tick(1);
    ia.rd_req_i = 0; ia.sema_valid_i = 0;
    @(negedge clk);
    chk("t1_busy_release", ia.busy_o, 1'b1);
    chk("t1_rd_hold", ia.rd_data_o, 1'b1);
    tick(1);
    @(negedge clk);
    chk("t1_busy_idle", ia.busy_o, 1'b0);
    tick(1);

    // Write stalled five cycles on sema_is_empty_i.
    ia.sema_is_empty_i = 0; ia.wr_data_i = 1; ia.wr_req_i = 1;
    q_a.push_back('{is_rd:1'b0, tmo:1'b0, rd:1'b1, wd:1'b1, cyc:cyc + 7});
    tick(3);
    @(negedge clk);
    chk("t2_busy_wait", ia.busy_o, 1'b1);
    tick(3);
    ia.sema_is_empty_i = 1;
    wait_done(1'b0, 8);
    tick(1);
    ia.wr_req_i = 0; ia.sema_is_empty_i = 0;
    @(negedge clk);
    chk("t2_write_once", ia.sema_write_o, 1'b0);
    tick(1);

    // TIMEOUT_CYCLES=4: valid arrives on the 4th wait cycle, read still wins.
    ib.sema_valid_i = 0; ib.sema_data_i = 1; ib.rd_req_i = 1;
    q_b.push_back('{is_rd:1'b1, tmo:1'b0, rd:1'b1, wd:1'b0, cyc:cyc + 5});
    tick(4);
    ib.sema_valid_i = 1;
    wait_done(1'b1, 8);
    tick(1);
    ib.rd_req_i = 0; ib.sema_valid_i = 0;
    tick(2);

    // TIMEOUT_CYCLES=4: read never satisfied, aborts on 4th wait cycle.
    ib.sema_data_i = 0; ib.rd_req_i = 1;
    q_b.push_back('{is_rd:1'b1, tmo:1'b1, rd:1'b1, wd:1'b0, cyc:cyc + 4});
    wait_done(1'b1, 10);
    tick(1);
    ib.rd_req_i = 0; ib.sema_valid_i = 1;
    @(negedge clk);
    chk("t4_ready_in_release", ib.sema_ready_o, 1'b0);
    chk("t4_rd_unchanged", ib.rd_data_o, 1'b1);
    tick(1);
    ib.sema_valid_i = 0;
    tick(1);

    // TIMEOUT_CYCLES=4: write never satisfied, aborts with no write strobe.
    ib.sema_is_empty_i = 0; ib.wr_data_i = 1; ib.wr_req_i = 1;
    q_b.push_back('{is_rd:1'b0, tmo:1'b1, rd:1'b1, wd:1'b1, cyc:cyc + 4});
    wait_done(1'b1, 10);
    tick(1);
    ib.wr_req_i = 0;
    tick(2);

    // Simultaneous read and write: read first, write after RELEASE.
    ia.sema_valid_i = 1; ia.sema_data_i = 0; ia.sema_is_empty_i = 1;
    ia.wr_data_i = 1; ia.rd_req_i = 1; ia.wr_req_i = 1;
    q_a.push_back('{is_rd:1'b1, tmo:1'b0, rd:1'b0, wd:1'b0, cyc:cyc + 2});
    q_a.push_back('{is_rd:1'b0, tmo:1'b0, rd:1'b0, wd:1'b1, cyc:cyc + 6});
    wait_done(1'b0, 8);
    tick(1);
    ia.rd_req_i = 0;
    wait_done(1'b0, 8);
    tick(1);
    ia.wr_req_i = 0; ia.sema_valid_i = 0; ia.sema_is_empty_i = 0;
    tick(2);

    // Reset while in WR_WAIT with the memory becoming free: no strobe.
    ia.wr_data_i = 1; ia.wr_req_i = 1;
    tick(1);
    @(negedge clk);
    chk("t7_busy_wait", ia.busy_o, 1'b1);
    rstn_a = 0; ia.sema_is_empty_i = 1; ia.wr_req_i = 0;
    tick(1);
    rstn_a = 1;
    @(negedge clk);
    chk_int("t7_outputs_after_reset", int'({ia.done_o, ia.rd_data_o, ia.timeout_o, ia.busy_o,
            ia.sema_ready_o, ia.sema_write_o, ia.sema_data_o}), 0);
    tick(1);
    ia.wr_data_i = 1; ia.sema_is_empty_i = 1; ia.wr_req_i = 1;
    q_a.push_back('{is_rd:1'b0, tmo:1'b0, rd:1'b0, wd:1'b1, cyc:cyc + 2});
    wait_done(1'b0, 8);
    tick(1);
    ia.wr_req_i = 0; ia.sema_is_empty_i = 0;
    tick(3);

    chk_int("a_queue_drained", q_a.size(), 0);
    chk_int("b_queue_drained", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
